// File: rtl/prll_bs_rr_schdlr.sv
// Round-robin scheduler for the shared parallel bus between driver FIFOs.
// One transaction is IDLE -> POP -> PUSH; every output is a flop.
module prll_bs_rr_schdlr #(
  parameter int unsigned drvrs     = 8,
  parameter int unsigned bits      = 32,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int unsigned cnt_w     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [drvrs-1:0]      pndng,
  input  logic [drvrs*bits-1:0] D_pop,
  output logic [drvrs-1:0]      pop,
  output logic [drvrs-1:0]      push,
  output logic [bits-1:0]       D_push,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  drop,
  output logic [cnt_w-1:0]      trans_cnt,
  output logic [cnt_w-1:0]      drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_PUSH
  } state_e;

  state_e state_q, state_d;

  logic [drvrs-1:0] pop_q, pop_d;
  logic [drvrs-1:0] push_q, push_d;
  logic [bits-1:0]  d_push_q, d_push_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic [cnt_w-1:0] trans_cnt_q, trans_cnt_d;
  logic [cnt_w-1:0] drop_cnt_q, drop_cnt_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;

  // Pad requests and head words to 8 slots so 3-bit indices always fit
  logic [7:0]      pnd8;
  logic [bits-1:0] words [8];

  assign pnd8 = 8'(pndng);

  for (genvar i = 0; i < 8; i++) begin : g_word
    if (i < int'(drvrs)) begin : g_act
      assign words[i] = D_pop[i*bits +: bits];
    end else begin : g_pad
      assign words[i] = '0;
    end
  end

  logic [2:0] g_sel;
  logic [3:0] scan;
  logic       found;

  always_comb begin
    g_sel = rr_ptr_q;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < int'(drvrs); k++) begin
      scan = {1'b0, rr_ptr_q} + 4'(k);
      if (scan >= 4'(drvrs)) begin
        scan = scan - 4'(drvrs);
      end
      if (!found && pnd8[scan[2:0]]) begin
        g_sel = scan[2:0];
        found = 1'b1;
      end
    end
  end

  logic [bits-1:0] word_g;
  logic [7:0]      dest;
  logic            is_bc;
  logic            is_uc;
  logic [7:0]      pop8;
  logic [7:0]      uc8;
  logic [7:0]      bc8;
  logic [2:0]      rr_nxt;

  assign word_g = words[grant_id_q];
  assign dest   = word_g[bits-1 -: 8];
  assign is_bc  = (dest == broadcast);
  assign is_uc  = !is_bc && (dest < 8'(drvrs));
  assign pop8   = 8'b1 << g_sel;
  assign uc8    = 8'b1 << dest[2:0];
  assign bc8    = ~(8'b1 << grant_id_q);
  assign rr_nxt = (grant_id_q == 3'(drvrs - 1)) ? 3'd0
                                                : grant_id_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (found) state_d = S_POP;
      S_POP:  state_d = S_PUSH;
      S_PUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop_d       = '0;
    push_d      = '0;
    drop_d      = 1'b0;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    d_push_d    = d_push_q;
    rr_ptr_d    = rr_ptr_q;
    trans_cnt_d = trans_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = found;
        if (found) begin
          grant_id_d = g_sel;
          pop_d      = pop8[drvrs-1:0];
        end
      end
      S_POP: begin
        busy_d   = 1'b1;
        d_push_d = word_g;
        rr_ptr_d = rr_nxt;
        // Routing is decided from the popped head word itself
        unique case (1'b1)
          is_bc: begin
            push_d      = bc8[drvrs-1:0];
            trans_cnt_d = trans_cnt_q + cnt_w'(1);
          end
          is_uc: begin
            push_d      = uc8[drvrs-1:0];
            trans_cnt_d = trans_cnt_q + cnt_w'(1);
          end
          default: begin
            drop_d     = 1'b1;
            drop_cnt_d = drop_cnt_q + cnt_w'(1);
          end
        endcase
      end
      S_PUSH: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q       <= '0;
      push_q      <= '0;
      d_push_q    <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      trans_cnt_q <= '0;
      drop_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      pop_q       <= pop_d;
      push_q      <= push_d;
      d_push_q    <= d_push_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      trans_cnt_q <= trans_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign pop       = pop_q;
  assign push      = push_q;
  assign D_push    = d_push_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign drop      = drop_q;
  assign trans_cnt = trans_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_prll_bs_rr_schdlr.sv
// Bench for prll_bs_rr_schdlr: vector table, hand sequences and a
// scoreboard fed by an independent arbitration/routing model.
module tb_prll_bs_rr_schdlr;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   pndng;
  logic [255:0] d_pop;
  logic [7:0]   pop;
  logic [7:0]   push;
  logic [31:0]  d_push;
  logic [2:0]   grant_id;
  logic         busy;
  logic         drop;
  logic [15:0]  trans_cnt;
  logic [15:0]  drop_cnt;

  logic [31:0]  wd [8];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) d_pop[i*32 +: 32] = wd[i];
  end

  prll_bs_rr_schdlr dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .D_pop     (d_pop),
    .pop       (pop),
    .push      (push),
    .D_push    (d_push),
    .grant_id  (grant_id),
    .busy      (busy),
    .drop      (drop),
    .trans_cnt (trans_cnt),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  push;
    logic [31:0] data;
    logic        drop;
    logic [15:0] tc;
    logic [15:0] dc;
  } exp_t;

  exp_t        sbq [$];
  exp_t        e;
  logic        rst_edge = 1'b1;
  logic [7:0]  prev_pnd = 8'h00;
  logic [2:0]  m_rr = 3'd0;
  logic [15:0] m_tc = 16'd0;
  logic [15:0] m_dc = 16'd0;
  logic [2:0]  mg;
  logic [2:0]  midx;
  logic        mfound;
  logic [31:0] mw;
  logic [7:0]  mep;

  always @(posedge clk) rst_edge = !reset;

  always @(negedge clk) begin
    if (rst_edge) begin
      sbq.delete();
      m_rr = 3'd0;
      m_tc = 16'd0;
      m_dc = 16'd0;
    end else begin
      if (push != 8'h00 || drop) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_out", 64'({push, drop}), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_push", 64'(push), 64'(e.push));
          chk("sb_drop", 64'(drop), 64'(e.drop));
          if (e.push != 8'h00) chk("sb_data", 64'(d_push), 64'(e.data));
          chk("sb_trans_cnt", 64'(trans_cnt), 64'(e.tc));
          chk("sb_drop_cnt", 64'(drop_cnt), 64'(e.dc));
        end
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_missing_out", 64'({push, drop}), 64'({e.push, e.drop}));
      end
      if (pop != 8'h00) begin
        mfound = 1'b0;
        mg     = 3'd0;
        for (int k = 0; k < 8; k++) begin
          midx = m_rr + 3'(k);
          if (!mfound && prev_pnd[midx]) begin
            mg     = midx;
            mfound = 1'b1;
          end
        end
        if (!mfound) begin
          chk("sb_spurious_pop", 64'(pop), 64'd0);
        end else begin
          chk("sb_pop", 64'(pop), 64'(8'b1 << mg));
          chk("sb_grant", 64'(grant_id), 64'(mg));
          chk("sb_busy", 64'(busy), 64'd1);
          m_rr = mg + 3'd1;
          mw   = wd[mg];
          if (mw[31:24] == 8'hFF) begin
            mep  = ~(8'b1 << mg);
            m_tc = m_tc + 16'd1;
          end else if (mw[31:24] < 8'd8) begin
            mep  = 8'b1 << mw[26:24];
            m_tc = m_tc + 16'd1;
          end else begin
            mep  = 8'h00;
            m_dc = m_dc + 16'd1;
          end
          sbq.push_back('{mep, mw, (mep == 8'h00), m_tc, m_dc});
        end
      end
    end
    prev_pnd = pndng;
  end

  typedef struct {
    logic [7:0]  pnd;
    logic [31:0] w;
    logic [7:0]  e_pop;
    logic [7:0]  e_push;
    logic        e_drop;
  } vec_t;

  vec_t vt [11];

  task automatic run_vec(input vec_t v, input int n);
    @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      wd[i] = v.e_pop[i] ? v.w : (v.w ^ 32'h0000_5500);
    end
    pndng = v.pnd;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pop != 8'h00) break;
    end
    chk($sformatf("v%0d_pop", n), 64'(pop), 64'(v.e_pop));
    @(posedge clk);
    #2;
    pndng = 8'h00;
    @(negedge clk);
    chk($sformatf("v%0d_push", n), 64'(push), 64'(v.e_push));
    chk($sformatf("v%0d_drop", n), 64'(drop), 64'(v.e_drop));
    if (!v.e_drop) chk($sformatf("v%0d_data", n), 64'(d_push), 64'(v.w));
    @(negedge clk);
    chk($sformatf("v%0d_idle", n), 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] gseq [$];
    int         npop;
    int         exp_tc;
    int         exp_dc;

    vt[0]  = '{8'h08, 32'h0500ABCD, 8'h08, 8'h20, 1'b0};
    vt[1]  = '{8'h04, 32'hFF001234, 8'h04, 8'hFB, 1'b0};
    vt[2]  = '{8'h20, 32'h09005678, 8'h20, 8'h00, 1'b1};
    vt[3]  = '{8'hFF, 32'h00000001, 8'h40, 8'h01, 1'b0};
    vt[4]  = '{8'h81, 32'h0300BEEF, 8'h80, 8'h08, 1'b0};
    vt[5]  = '{8'h81, 32'h07000000, 8'h01, 8'h80, 1'b0};
    vt[6]  = '{8'h01, 32'h00000042, 8'h01, 8'h01, 1'b0};
    vt[7]  = '{8'h10, 32'h08001111, 8'h10, 8'h00, 1'b1};
    vt[8]  = '{8'h10, 32'h07002222, 8'h10, 8'h80, 1'b0};
    vt[9]  = '{8'h0C, 32'hFE000000, 8'h04, 8'h00, 1'b1};
    vt[10] = '{8'h0C, 32'hFF00AAAA, 8'h08, 8'hF7, 1'b0};

    reset = 1'b0;
    pndng = 8'hFF;
    for (int i = 0; i < 8; i++) wd[i] = {8'h00, 8'(i), 16'h1234};

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst_outs_c%0d", c),
          64'({pop, push, grant_id, busy, drop}), 64'd0);
      chk($sformatf("rst_data_c%0d", c), 64'(d_push), 64'd0);
      chk($sformatf("rst_cnts_c%0d", c),
          64'({trans_cnt, drop_cnt}), 64'd0);
    end

    @(posedge clk);
    #2;
    reset = 1'b1;
    npop  = 0;
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      if (n == 1) chk("rel_pop_c1", 64'(pop), 64'd0);
      if (n == 2) chk("rel_pop_c2", 64'(pop), 64'h01);
      if (pop != 8'h00) begin
        npop++;
        gseq.push_back(grant_id);
      end
    end
    chk("rr_pop_count", 64'(npop), 64'd9);
    for (int i = 0; i < gseq.size(); i++) begin
      chk($sformatf("rr_grant_%0d", i), 64'(gseq[i]), 64'(i % 8));
    end
    chk("rr_trans_cnt", 64'(trans_cnt), 64'd9);
    @(posedge clk);
    #2;
    pndng = 8'h00;
    @(negedge clk);
    @(negedge clk);

    exp_tc = 9;
    exp_dc = 0;
    for (int n = 0; n < 11; n++) begin
      run_vec(vt[n], n);
      if (vt[n].e_drop) exp_dc++;
      else exp_tc++;
      if (n == 2) chk("v2_drop_cnt", 64'(drop_cnt), 64'd1);
    end
    chk("tbl_trans_cnt", 64'(trans_cnt), 64'(exp_tc));
    chk("tbl_drop_cnt", 64'(drop_cnt), 64'(exp_dc));

    @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) wd[i] = {8'h00, 8'(i), 16'h0F0F};
    pndng = 8'h02;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pop != 8'h00) break;
    end
    chk("r6_pop", 64'(pop), 64'h02);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("r6_outs", 64'({pop, push, grant_id, busy, drop}), 64'd0);
    chk("r6_cnts", 64'({trans_cnt, drop_cnt}), 64'd0);
    chk("r6_data", 64'(d_push), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pop != 8'h00) break;
    end
    chk("r6_regrant_pop", 64'(pop), 64'h02);
    chk("r6_regrant_id", 64'(grant_id), 64'd1);
    @(posedge clk);
    #2;
    pndng = 8'h00;
    @(negedge clk);
    chk("r6_push", 64'(push), 64'h01);
    chk("r6_trans_cnt", 64'(trans_cnt), 64'd1);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
